// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the MEM stage and a
// word-addressed data memory. Handles LW/SW in one cycle and LDW/SDW as two
// beats (stalling upstream for the second), and turns out-of-range or
// misaligned requests into a one-cycle addr_fault pulse without touching memory.
module mem_access_unit #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  output logic [31:0] resp_data0,
  output logic [31:0] resp_data1,
  output logic        addr_fault
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BEAT1 = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            load_q, load_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata1_q, wdata1_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_data0_q, resp_data0_d;
  logic [DW-1:0]   resp_data1_q, resp_data1_d;
  logic            addr_fault_q, addr_fault_d;

  logic            legal_c;
  logic            accept_c;

  // Request legality: in range, and doubles must start on an even word.
  assign legal_c  = (req_addr < AW'(MEM_DEPTH)) && (!req_op[1] || !req_addr[0]);
  // A request is accepted only in IDLE and never while reset is held.
  assign accept_c = (state_q == IDLE) && req_valid && legal_c && !reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a legal double-word op takes one extra beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c && req_op[1]) state_d = BEAT1;
      BEAT1:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes and stall, combinational from state and request.
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    stall          = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          mem_address = req_addr;
          stall       = req_op[1];
          if (req_op[0]) begin
            mem_write      = 1'b1;
            mem_write_data = req_wdata0;
          end else begin
            mem_read = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (!reset) begin
          mem_address = addr_q;
          if (load_q) begin
            mem_read = 1'b1;
          end else begin
            mem_write      = 1'b1;
            mem_write_data = wdata1_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Second-beat latches, response capture and fault detection.
  always_comb begin
    load_d       = load_q;
    addr_d       = addr_q;
    wdata1_d     = wdata1_q;
    resp_valid_d = 1'b0;
    resp_data0_d = resp_data0_q;
    resp_data1_d = resp_data1_q;
    addr_fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !legal_c) begin
          addr_fault_d = 1'b1;
        end else if (accept_c) begin
          if (!req_op[0]) resp_data0_d = mem_read_data;
          if (req_op[1]) begin
            load_d   = !req_op[0];
            addr_d   = req_addr + AW'(1);
            wdata1_d = req_wdata1;
          end else if (!req_op[0]) begin
            resp_data1_d = '0;
            resp_valid_d = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (load_q) begin
          resp_data1_d = mem_read_data;
          resp_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q       <= 1'b0;
      addr_q       <= '0;
      wdata1_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data0_q <= '0;
      resp_data1_q <= '0;
      addr_fault_q <= 1'b0;
    end else begin
      load_q       <= load_d;
      addr_q       <= addr_d;
      wdata1_q     <= wdata1_d;
      resp_valid_q <= resp_valid_d;
      resp_data0_q <= resp_data0_d;
      resp_data1_q <= resp_data1_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data0 = resp_data0_q;
  assign resp_data1 = resp_data1_q;
  assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: attaches a word-addressed memory (sync write,
// comb read) and checks strobes, stalls, responses and faults against a
// reference memory image and expected-response registers kept here.
module tb_mem_access_unit;

  localparam logic [1:0] LW = 2'b00, SW = 2'b01, LDW = 2'b10, SDW = 2'b11;

  logic        clk, reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata0, req_wdata1;
  logic        stall, mem_write, mem_read;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        resp_valid, addr_fault;
  logic [31:0] resp_data0, resp_data1;
  logic        mem_init;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_d0, exp_d1;
  int checks, failures;

  mem_access_unit #(.MEM_DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .stall(stall), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .resp_valid(resp_valid), .resp_data0(resp_data0), .resp_data1(resp_data1),
    .addr_fault(addr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= {16'(i), 16'hA5A5};
    end else if (mem_write && mem_address < 32'd1024) begin
      mem[mem_address[9:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'h0;

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] w0, input logic [31:0] w1);
    req_valid = v; req_op = op; req_addr = a; req_wdata0 = w0; req_wdata1 = w1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1;
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = {16'(i), 16'hA5A5};
    exp_d0 = 32'd0; exp_d1 = 32'd0;
    step();
    mem_init = 1'b0;
    drive(1'b1, LW, 32'd5, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if ({mem_read, mem_write, stall} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b want=000", {mem_read, mem_write, stall}); end
    checks++; if ({resp_valid, addr_fault} !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b want=00", {resp_valid, addr_fault}); end
    checks++; if ({resp_data0, resp_data1} !== 64'd0) begin failures++; $display("FAIL rst_data got=%h want=0", {resp_data0, resp_data1}); end
    step();
    reset = 1'b0;
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if ({mem_read, mem_write, stall, mem_address, mem_write_data} !== 67'd0) begin failures++; $display("FAIL idle_outputs got=%b/%h/%h want=0", {mem_read, mem_write, stall}, mem_address, mem_write_data); end
    step();
  endtask

  task automatic test_sw_lw();
    drive(1'b1, SW, 32'd5, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    checks++; if ({mem_read, mem_write, stall} !== 3'b010) begin failures++; $display("FAIL sw_strobes got=%b want=010", {mem_read, mem_write, stall}); end
    checks++; if (mem_address !== 32'd5 || mem_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_bus got=%h/%h want=5/deadbeef", mem_address, mem_write_data); end
    step();
    ref_mem[5] = 32'hDEADBEEF;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sw_no_resp got=%b want=0", resp_valid); end
    drive(1'b1, LW, 32'd5, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if ({mem_read, mem_write, stall} !== 3'b100 || mem_address !== 32'd5) begin failures++; $display("FAIL lw_strobes got=%b@%h want=100@5", {mem_read, mem_write, stall}, mem_address); end
    step();
    exp_d0 = 32'hDEADBEEF; exp_d1 = 32'd0;
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL lw_resp_valid got=%b want=1", resp_valid); end
    checks++; if (resp_data0 !== exp_d0 || resp_data1 !== exp_d1) begin failures++; $display("FAIL lw_resp_data got=%h/%h want=%h/%h", resp_data0, resp_data1, exp_d0, exp_d1); end
    step();
    checks++; if (resp_valid !== 1'b0 || resp_data0 !== exp_d0) begin failures++; $display("FAIL lw_pulse_hold got=%b/%h want=0/%h", resp_valid, resp_data0, exp_d0); end
  endtask

  task automatic test_double(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
    drive(1'b1, SDW, a, w0, w1);
    @(negedge clk);
    checks++; if ({mem_read, mem_write, stall} !== 3'b011 || mem_address !== a || mem_write_data !== w0) begin failures++; $display("FAIL sdw_beat0 got=%b@%h:%h want=011@%h:%h", {mem_read, mem_write, stall}, mem_address, mem_write_data, a, w0); end
    step();
    checks++; if ({mem_read, mem_write, stall} !== 3'b010 || mem_address !== a + 32'd1 || mem_write_data !== w1) begin failures++; $display("FAIL sdw_beat1 got=%b@%h:%h want=010@%h:%h", {mem_read, mem_write, stall}, mem_address, mem_write_data, a + 32'd1, w1); end
    step();
    ref_mem[a[9:0]] = w0; ref_mem[a[9:0] + 10'd1] = w1;
    checks++; if (mem[a[9:0]] !== w0 || mem[a[9:0] + 10'd1] !== w1) begin failures++; $display("FAIL sdw_commit got=%h/%h want=%h/%h", mem[a[9:0]], mem[a[9:0] + 10'd1], w0, w1); end
    drive(1'b1, LDW, a, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if ({mem_read, mem_write, stall} !== 3'b101 || mem_address !== a) begin failures++; $display("FAIL ldw_beat0 got=%b@%h want=101@%h", {mem_read, mem_write, stall}, mem_address, a); end
    step();
    checks++; if ({mem_read, mem_write, stall} !== 3'b100 || mem_address !== a + 32'd1 || resp_valid !== 1'b0) begin failures++; $display("FAIL ldw_beat1 got=%b@%h rv=%b want=100@%h rv=0", {mem_read, mem_write, stall}, mem_address, resp_valid, a + 32'd1); end
    step();
    exp_d0 = ref_mem[a[9:0]]; exp_d1 = ref_mem[a[9:0] + 10'd1];
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    checks++; if (resp_valid !== 1'b1 || addr_fault !== 1'b0) begin failures++; $display("FAIL ldw_resp got=rv%b af%b want=rv1 af0", resp_valid, addr_fault); end
    checks++; if (resp_data0 !== exp_d0 || resp_data1 !== exp_d1) begin failures++; $display("FAIL ldw_data got=%h/%h want=%h/%h", resp_data0, resp_data1, exp_d0, exp_d1); end
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL ldw_pulse got=%b want=0", resp_valid); end
  endtask

  task automatic test_faults();
    logic [1:0]  ops   [4] = '{LW, LDW, SDW, SW};
    logic [31:0] addrs [4] = '{32'd1024, 32'd7, 32'd1023, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], addrs[i], 32'h0BADF00D, 32'h0BADF00D);
      @(negedge clk);
      checks++; if ({mem_read, mem_write, stall} !== 3'b000) begin failures++; $display("FAIL fault_strobes[%0d] got=%b want=000", i, {mem_read, mem_write, stall}); end
      step();
      drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
      checks++; if ({addr_fault, resp_valid} !== 2'b10) begin failures++; $display("FAIL fault_pulse[%0d] got=af%b rv%b want=af1 rv0", i, addr_fault, resp_valid); end
      checks++; if (resp_data0 !== exp_d0 || resp_data1 !== exp_d1) begin failures++; $display("FAIL fault_data[%0d] got=%h/%h want=%h/%h", i, resp_data0, resp_data1, exp_d0, exp_d1); end
      step();
      checks++; if (addr_fault !== 1'b0) begin failures++; $display("FAIL fault_one_cycle[%0d] got=%b want=0", i, addr_fault); end
    end
  endtask

  task automatic test_reset_beat1();
    logic [31:0] w0, w1, old13;
    w0 = $urandom; w1 = ~w0; old13 = ref_mem[13];
    drive(1'b1, SDW, 32'd12, w0, w1);
    step();
    reset = 1'b1;
    #1;
    checks++; if ({mem_read, mem_write, stall} !== 3'b000) begin failures++; $display("FAIL rstb1_strobes got=%b want=000", {mem_read, mem_write, stall}); end
    checks++; if ({resp_valid, addr_fault} !== 2'b00 || {resp_data0, resp_data1} !== 64'd0) begin failures++; $display("FAIL rstb1_outputs got=%b %h/%h want=0", {resp_valid, addr_fault}, resp_data0, resp_data1); end
    ref_mem[12] = w0; exp_d0 = 32'd0; exp_d1 = 32'd0;
    step();
    checks++; if (mem[12] !== w0 || mem[13] !== old13) begin failures++; $display("FAIL rstb1_mem got=%h/%h want=%h/%h", mem[12], mem[13], w0, old13); end
    reset = 1'b0;
    drive(1'b1, LW, 32'd12, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if ({mem_read, mem_write, stall} !== 3'b100 || mem_address !== 32'd12) begin failures++; $display("FAIL rstb1_accept got=%b@%h want=100@c", {mem_read, mem_write, stall}, mem_address); end
    step();
    exp_d0 = w0;
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    checks++; if (resp_valid !== 1'b1 || resp_data0 !== exp_d0 || resp_data1 !== exp_d1) begin failures++; $display("FAIL rstb1_lw got=%b %h/%h want=1 %h/%h", resp_valid, resp_data0, resp_data1, exp_d0, exp_d1); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, w0, e0, last_sw;
    int n_lw, n_resp;
    n_lw = 0; n_resp = 0; last_sw = 32'd0;
    for (int i = 0; i < 20; i++) begin
      a  = ((i % 4) == 2) ? last_sw : 32'($urandom_range(0, 1023));
      w0 = $urandom;
      e0 = ref_mem[a[9:0]];
      drive(1'b1, (i % 2 == 0) ? LW : SW, a, w0, 32'd0);
      @(negedge clk);
      checks++; if (stall !== 1'b0 || (mem_read && mem_write) || mem_address !== a || {mem_read, mem_write} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_strobes[%0d] got=%b@%h want=%s@%h", i, {mem_read, mem_write, stall}, mem_address, (i % 2 == 0) ? "100" : "010", a); end
      step();
      if (resp_valid === 1'b1) n_resp++;
      if (i % 2 == 0) begin
        n_lw++;
        exp_d0 = e0; exp_d1 = 32'd0;
        checks++; if (resp_valid !== 1'b1 || resp_data0 !== exp_d0 || resp_data1 !== 32'd0) begin failures++; $display("FAIL b2b_lw[%0d] got=%b %h/%h want=1 %h/0", i, resp_valid, resp_data0, resp_data1, exp_d0); end
      end else begin
        ref_mem[a[9:0]] = w0; last_sw = a;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_sw[%0d] got=%b want=0", i, resp_valid); end
      end
    end
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    checks++; if (n_resp !== n_lw) begin failures++; $display("FAIL b2b_resp_count got=%0d want=%0d", n_resp, n_lw); end
    step();
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, w0, w1, e0, e1;
    logic        legal;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       a = 32'd1024 + 32'($urandom_range(0, 4000));
        1:       a = 32'hFFFF_FFFE;
        default: a = 32'($urandom_range(0, 1023));
      endcase
      w0 = $urandom; w1 = $urandom;
      legal = (a < 32'd1024) && (!op[1] || !a[0]);
      e0 = ref_mem[a[9:0]];
      e1 = (op == LDW) ? ref_mem[a[9:0] + 10'd1] : 32'd0;
      drive(1'b1, op, a, w0, w1);
      @(negedge clk);
      checks++; if ({mem_read, mem_write, stall} !== (legal ? {~op[0], op[0], op[1]} : 3'b000)) begin failures++; $display("FAIL rnd_beat0[%0d] op=%0d a=%h got=%b", i, op, a, {mem_read, mem_write, stall}); end
      if (legal) begin
        checks++; if (mem_address !== a || (op[0] && mem_write_data !== w0)) begin failures++; $display("FAIL rnd_bus0[%0d] got=%h:%h want=%h:%h", i, mem_address, mem_write_data, a, w0); end
      end
      if (legal && op[1]) begin
        step();
        checks++; if ({mem_read, mem_write, stall} !== {~op[0], op[0], 1'b0} || mem_address !== a + 32'd1 || (op[0] && mem_write_data !== w1) || resp_valid !== 1'b0) begin failures++; $display("FAIL rnd_beat1[%0d] got=%b@%h:%h rv=%b", i, {mem_read, mem_write, stall}, mem_address, mem_write_data, resp_valid); end
      end
      step();
      if (legal) begin
        if (op[0]) begin
          ref_mem[a[9:0]] = w0;
          if (op[1]) ref_mem[a[9:0] + 10'd1] = w1;
        end else begin
          exp_d0 = e0; exp_d1 = e1;
        end
      end
      checks++; if (resp_valid !== (legal && !op[0]) || addr_fault !== !legal) begin failures++; $display("FAIL rnd_pulses[%0d] got=rv%b af%b want=rv%b af%b", i, resp_valid, addr_fault, legal && !op[0], !legal); end
      checks++; if (resp_data0 !== exp_d0 || resp_data1 !== exp_d1) begin failures++; $display("FAIL rnd_data[%0d] got=%h/%h want=%h/%h", i, resp_data0, resp_data1, exp_d0, exp_d1); end
    end
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    step();
  endtask

  task automatic test_memory_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL mem_image got=%0d differing words want=0", bad); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; mem_init = 1'b0;
    drive(1'b0, LW, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_sw_lw();
    test_double(32'd8, 32'h11111111, 32'h22222222);
    test_faults();
    test_double(32'd1022, $urandom, $urandom);
    test_reset_beat1();
    test_back_to_back();
    test_random();
    test_memory_image();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
